// File: rtl/lsr_op_pipe_if.sv
// Request/result bundle between the ALSU decoder, lsr_op_pipe, the
// combinational logic/shift/rotate unit and the writeback path.
interface lsr_op_pipe_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned FC_W = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_a;
    logic [3:0]      in_b;
    logic [2:0]      in_sel;
    logic [3:0]      lsr_a;
    logic [3:0]      lsr_b;
    logic [2:0]      lsr_sel;
    logic [3:0]      lsr_out;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_result;
    logic [2:0]      out_sel;
    logic [FC_W-1:0] fifo_count;
    logic [CNT_W-1:0] ops_done;

    modport slave (
        input  in_valid, in_a, in_b, in_sel, lsr_out, out_ready,
        output in_ready, lsr_a, lsr_b, lsr_sel,
               out_valid, out_result, out_sel, fifo_count, ops_done
    );

    modport master (
        output in_valid, in_a, in_b, in_sel, lsr_out, out_ready,
        input  in_ready, lsr_a, lsr_b, lsr_sel,
               out_valid, out_result, out_sel, fifo_count, ops_done
    );
endinterface

// File: rtl/lsr_op_pipe.sv
// Issue/retire stage around the 4-bit logic/shift/rotate unit: request FIFO
// feeding the unit, registered result with valid/ready back-pressure.
module lsr_op_pipe #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    lsr_op_pipe_if.slave    bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0]       out_result_q, out_result_d;
    logic [2:0]       out_sel_q, out_sel_d;
    logic [CNT_W-1:0] ops_done_q, ops_done_d;

    logic   in_ready;
    logic   push;
    logic   pop;
    logic   accept_out;
    entry_t head;

    always_comb begin
        in_ready   = (count_q < FULL) && !rst;
        push       = bus.in_valid && in_ready;
        accept_out = out_valid_q && bus.out_ready;
        // A request pushed into an empty FIFO is never popped the same edge:
        // pop only looks at the registered count.
        pop        = (count_q != '0) && (!out_valid_q || bus.out_ready);
        head       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{a: bus.in_a, b: bus.in_b, sel: bus.in_sel};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_sel_d    = out_sel_q;
        ops_done_d   = ops_done_q;
        if (pop) begin
            out_valid_d  = 1'b1;
            out_result_d = bus.lsr_out;
            out_sel_d    = head.sel;
        end else if (accept_out) begin
            out_valid_d  = 1'b0;
        end
        if (accept_out) begin
            ops_done_d = ops_done_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_sel_q    <= '0;
            ops_done_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_sel_q    <= out_sel_d;
            ops_done_q   <= ops_done_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.in_ready   = in_ready;
    assign bus.lsr_a      = head.a;
    assign bus.lsr_b      = head.b;
    assign bus.lsr_sel    = head.sel;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_sel    = out_sel_q;
    assign bus.fifo_count = count_q;
    assign bus.ops_done   = ops_done_q;

endmodule

// File: tb/tb_lsr_op_pipe.sv
// Scoreboard bench for lsr_op_pipe with an XOR stand-in for the
// logic/shift/rotate unit and a queue model of in-flight requests.
module tb_lsr_op_pipe;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
    } req_t;

    logic clk;
    logic rst;

    lsr_op_pipe_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    lsr_op_pipe #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.lsr_out = bus.lsr_a ^ bus.lsr_b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    req_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   model_ops = 0;
    bit   track_fc = 1'b0;
    int   max_fc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: everything in flight is either in the FIFO or in the
    // result register; the oldest request is the next result out.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_ops = 0;
        end else begin
            int    held;
            int    hidx;
            req_t  r;
            held = (bus.out_valid === 1'b1) ? 1 : 0;
            chk("occupancy", 32'(int'(bus.fifo_count) + held), 32'(exp_q.size()));
            chk("ops_done", 32'(bus.ops_done), 32'(model_ops % (1 << CNT_W)));
            if (track_fc && int'(bus.fifo_count) > max_fc) max_fc = int'(bus.fifo_count);
            if (bus.fifo_count == 0) begin
                chk("head_empty", {21'b0, bus.lsr_a, bus.lsr_b, bus.lsr_sel}, 32'd0);
            end else begin
                hidx = held;
                if (exp_q.size() > hidx) begin
                    r = exp_q[hidx];
                    chk("head", {21'b0, bus.lsr_a, bus.lsr_b, bus.lsr_sel}, {21'b0, r});
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("stale_result", 32'(bus.out_valid), 32'd0);
                end else begin
                    r = exp_q.pop_front();
                    chk("result", {24'b0, bus.out_sel, 1'b0, bus.out_result},
                        {24'b0, r.sel, 1'b0, r.a ^ r.b});
                    model_ops++;
                end
            end
        end
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
        bit acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sel   = sel;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back('{a: a, b: b, sel: sel});
                break;
            end
            #1;
        end
        chk("accept", 32'(acc), 32'd1);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.out_valid === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = 4'h7;
        bus.in_b      = 4'h2;
        bus.in_sel    = 3'd1;
        bus.out_ready = 1'b0;

        // Reset held two cycles with a request offered
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
        chk("rst_ops_done", 32'(bus.ops_done), 32'd0);
        chk("rst_lsr", {21'b0, bus.lsr_a, bus.lsr_b, bus.lsr_sel}, 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single op: result one edge after acceptance
        bus.out_ready = 1'b1;
        send(4'hA, 4'h3, 3'd5);
        @(negedge clk);
        chk("single_pending", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("single_valid", 32'(bus.out_valid), 32'd1);
        chk("single_result", 32'(bus.out_result), 32'h9);
        chk("single_sel", 32'(bus.out_sel), 32'd5);
        @(negedge clk);
        chk("single_ops", 32'(bus.ops_done), 32'd1);
        @(posedge clk);
        #1;

        // Streaming
        max_fc = 0;
        track_fc = 1'b1;
        for (int i = 0; i < 8; i++) send(4'(i), 4'hF, 3'($urandom_range(0, 7)));
        wait_drain();
        track_fc = 1'b0;
        chk("stream_max_count_le1", 32'(max_fc <= 1), 32'd1);
        chk("stream_ops", 32'(bus.ops_done), 32'd9);

        // Back-pressure until full, then pop with a blocked push
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(4'($urandom), 4'($urandom), 3'($urandom));
        bus.in_valid = 1'b1;
        bus.in_a     = 4'h5;
        bus.in_b     = 4'hC;
        bus.in_sel   = 3'd6;
        @(negedge clk);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_count", 32'(bus.fifo_count), 32'd4);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("after_pop_count", 32'(bus.fifo_count), 32'd3);
        chk("after_pop_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        exp_q.push_back('{a: 4'h5, b: 4'hC, sel: 3'd6});
        #1;
        bus.in_valid = 1'b0;
        wait_drain();
        chk("drained_in_ready", 32'(bus.in_ready), 32'd1);

        // Random traffic with random back-pressure
        fork
            begin
                for (int c = 0; c < 300; c++) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
            begin
                for (int n = 0; n < 60; n++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(4'($urandom), 4'($urandom), 3'($urandom));
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_drain();

        // Reset with a held result and three queued requests
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4'($urandom), 4'($urandom), 3'($urandom));
        @(negedge clk);
        chk("pre_rst_count", 32'(bus.fifo_count), 32'd3);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_count", 32'(bus.fifo_count), 32'd0);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_ops", 32'(bus.ops_done), 32'd0);
        chk("mid_rst_out", {25'b0, bus.out_sel, bus.out_result}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(4'h6, 4'h1, 3'd2);
        wait_drain();
        chk("recover_ops", 32'(bus.ops_done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
